// File: rtl/gate_bus_pkg.sv
// Shared types and constants for the gate bus arbiter.
// State encoding, source indices, one-hot mux selects and small one-hot helpers.
package gate_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN  = 2'b01
  } arb_state_e;

  localparam int unsigned SRC_PC     = 0;
  localparam int unsigned SRC_MDR    = 1;
  localparam int unsigned SRC_ALU    = 2;
  localparam int unsigned SRC_MARMUX = 3;

  localparam logic [3:0] GATE_NONE   = 4'h0;
  localparam logic [3:0] GATE_PC     = 4'h1;
  localparam logic [3:0] GATE_MDR    = 4'h2;
  localparam logic [3:0] GATE_ALU    = 4'h4;
  localparam logic [3:0] GATE_MARMUX = 4'h8;

  // True when exactly one bit of a 4-bit vector is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
  endfunction

  // Index of the set bit of a one-hot vector (0 for an all-zero vector).
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = idx | (v[k] ? 2'(k) : 2'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gate_bus_arbiter_if.sv
// Bus-side handshake between the control state machine and the arbiter.
// master: request side (control FSM); slave: the arbiter.
interface gate_bus_arbiter_if;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] grant;
  logic [3:0] gate_sel;
  logic       bus_valid;
  logic       timeout;

  modport master (
    output req, lock,
    input  grant, gate_sel, bus_valid, timeout
  );

  modport slave (
    input  req, lock,
    output grant, gate_sel, bus_valid, timeout
  );
endinterface

// File: rtl/gate_bus_arbiter_rr_priority_pick.sv
// Rotating-priority requester pick: first set req bit found from ptr,
// wrapping upward modulo 4. Purely combinational.
module rr_priority_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] pick,
  output logic       any
);

  // Walk the four positions starting at ptr and mark only the first hit.
  always_comb begin
    logic [1:0] idx;
    logic       hit;
    pick = 4'h0;
    any  = 1'b0;
    idx  = 2'd0;
    hit  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx       = ptr + 2'(k);
      hit       = !any && req[idx];
      pick[idx] = pick[idx] | hit;
      any       = any | hit;
    end
  end

endmodule

// File: rtl/gate_bus_arbiter.sv
// Round-robin arbiter for the four gated sources of the 16-bit datapath bus.
// Registered one-hot grant doubles as the bus mux select; bus_valid qualifies it.
// Optional macro GATE_ARB_TIMEOUT_EN: bounds a locked owner to MAX_HOLD cycles
// and pulses timeout when it is forced off.
module gate_bus_arbiter
  import gate_bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  gate_bus_arbiter_if.slave   bus
);

  if ((MAX_HOLD < 1) || (MAX_HOLD > 15)) begin : g_bad_max_hold
    $error("gate_bus_arbiter: MAX_HOLD must be in 1..15");
  end

  arb_state_e state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] grant_q, grant_d;
  logic       bus_valid_q, bus_valid_d;

  logic [1:0] owner_s;
  logic [1:0] pick_ptr_s;
  logic [3:0] pick_s;
  logic       any_s;
  logic       locked_s;
  logic       hold_room_s;
  logic       new_grant_s;
  logic       extend_s;

  assign owner_s  = onehot_to_idx(grant_q);
  assign locked_s = bus.req[owner_s] & bus.lock[owner_s];
  // While owning, the next search starts just past the owner so a release
  // rotates priority; the owner itself is reached last and only wins alone.
  assign pick_ptr_s = (state_q == ST_OWN) ? (owner_s + 2'd1) : ptr_q;

  rr_priority_pick u_pick (
    .req  (bus.req),
    .ptr  (pick_ptr_s),
    .pick (pick_s),
    .any  (any_s)
  );

`ifdef GATE_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
  logic              forced_s;

  assign hold_room_s = (hold_cnt_q < HOLD_W'(MAX_HOLD));
  assign forced_s    = (state_q == ST_OWN) && is_onehot4(grant_q) &&
                       locked_s && !hold_room_s;

  // Hold counter starts at 1 on every new grant and counts extended cycles.
  always_comb begin
    hold_cnt_d = '0;
    timeout_d  = forced_s;
    if (new_grant_s) begin
      hold_cnt_d = HOLD_W'(1);
    end else if (extend_s) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end else begin
      hold_cnt_d = '0;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign hold_room_s = 1'b1;
  assign bus.timeout = 1'b0;
`endif

  // Next-state, pointer and grant decision.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    new_grant_s = 1'b0;
    extend_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          grant_d     = pick_s;
          state_d     = ST_OWN;
          new_grant_s = 1'b1;
        end else begin
          grant_d = GATE_NONE;
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (!is_onehot4(grant_q)) begin
          grant_d = GATE_NONE;
          state_d = ST_IDLE;
        end else if (locked_s && hold_room_s) begin
          extend_s = 1'b1;
        end else begin
          ptr_d = owner_s + 2'd1;
          if (any_s) begin
            grant_d     = pick_s;
            new_grant_s = 1'b1;
          end else begin
            grant_d = GATE_NONE;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        grant_d = GATE_NONE;
        state_d = ST_IDLE;
      end
    endcase
    bus_valid_d = is_onehot4(grant_d);
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd0;
      grant_q     <= GATE_NONE;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.gate_sel  = grant_q;
  assign bus.bus_valid = bus_valid_q;

endmodule

// File: tb/tb_gate_bus_arbiter.sv
// Directed, table-driven bench for gate_bus_arbiter plus hand sequences for
// reset, all-request rotation, lock hold/timeout and asynchronous reset.
module tb_gate_bus_arbiter;
  import gate_bus_pkg::*;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] grant;
    logic       valid;
    logic       tout;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gate_bus_arbiter_if bus_if ();

  gate_bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l,
                              input logic [3:0] g, input logic v, input logic t);
    vec_t x;
    x.req = r; x.lock = l; x.grant = g; x.valid = v; x.tout = t;
    return x;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] g, input logic v, input logic t);
    check({name, ".grant"},     bus_if.grant,             g);
    check({name, ".gate_sel"},  bus_if.gate_sel,          g);
    check({name, ".bus_valid"}, {3'b000, bus_if.bus_valid}, {3'b000, v});
    check({name, ".timeout"},   {3'b000, bus_if.timeout},   {3'b000, t});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_if.req  = 4'h0;
    bus_if.lock = 4'h0;
    rst_n       = 1'b0;
    tick();
    tick();
    check_out("reset", GATE_NONE, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  vec_t tbl[21];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus_if.req  = 4'h0;
    bus_if.lock = 4'h0;

    tbl[0]  = mk(4'b0100, 4'b0000, GATE_ALU,    1'b1, 1'b0);
    tbl[1]  = mk(4'b0000, 4'b0000, GATE_NONE,   1'b0, 1'b0);
    tbl[2]  = mk(4'b0000, 4'b0000, GATE_NONE,   1'b0, 1'b0);
    tbl[3]  = mk(4'b1111, 4'b0000, GATE_MARMUX, 1'b1, 1'b0);
    tbl[4]  = mk(4'b1111, 4'b0000, GATE_PC,     1'b1, 1'b0);
    tbl[5]  = mk(4'b1111, 4'b0000, GATE_MDR,    1'b1, 1'b0);
    tbl[6]  = mk(4'b1111, 4'b0000, GATE_ALU,    1'b1, 1'b0);
    tbl[7]  = mk(4'b1111, 4'b0000, GATE_MARMUX, 1'b1, 1'b0);
    tbl[8]  = mk(4'b1111, 4'b0000, GATE_PC,     1'b1, 1'b0);
    tbl[9]  = mk(4'b0011, 4'b0001, GATE_PC,     1'b1, 1'b0);
    tbl[10] = mk(4'b0011, 4'b0001, GATE_PC,     1'b1, 1'b0);
    tbl[11] = mk(4'b0011, 4'b0001, GATE_PC,     1'b1, 1'b0);
    tbl[12] = mk(4'b0011, 4'b0000, GATE_MDR,    1'b1, 1'b0);
    tbl[13] = mk(4'b0001, 4'b0000, GATE_PC,     1'b1, 1'b0);
    tbl[14] = mk(4'b0001, 4'b0000, GATE_PC,     1'b1, 1'b0);
    tbl[15] = mk(4'b0001, 4'b0001, GATE_PC,     1'b1, 1'b0);
    tbl[16] = mk(4'b0000, 4'b0001, GATE_NONE,   1'b0, 1'b0);
    tbl[17] = mk(4'b1000, 4'b1000, GATE_MARMUX, 1'b1, 1'b0);
    tbl[18] = mk(4'b1001, 4'b1000, GATE_MARMUX, 1'b1, 1'b0);
    tbl[19] = mk(4'b1001, 4'b0000, GATE_PC,     1'b1, 1'b0);
    tbl[20] = mk(4'b0000, 4'b0000, GATE_NONE,   1'b0, 1'b0);

    // Table-driven vectors from a fresh reset.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      bus_if.req  = tbl[i].req;
      bus_if.lock = tbl[i].lock;
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].grant, tbl[i].valid, tbl[i].tout);
    end

    // All four requesting from reset: strict 0,1,2,3,0 rotation.
    do_reset();
    bus_if.req = 4'b1111;
    tick(); check_out("rr0", GATE_PC,     1'b1, 1'b0);
    tick(); check_out("rr1", GATE_MDR,    1'b1, 1'b0);
    tick(); check_out("rr2", GATE_ALU,    1'b1, 1'b0);
    tick(); check_out("rr3", GATE_MARMUX, 1'b1, 1'b0);
    tick(); check_out("rr4", GATE_PC,     1'b1, 1'b0);

    // Locked PC competing with MARMUX.
    do_reset();
    bus_if.req  = 4'b1001;
    bus_if.lock = 4'b0001;
`ifdef GATE_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("hold%0d", i), GATE_PC, 1'b1, 1'b0);
    end
    tick(); check_out("forced", GATE_MARMUX, 1'b1, 1'b1);
    tick(); check_out("after_forced", GATE_PC, 1'b1, 1'b0);
`else
    for (int i = 0; i < 24; i++) begin
      tick();
      check_out($sformatf("hold%0d", i), GATE_PC, 1'b1, 1'b0);
    end
`endif

    // Asynchronous reset in the middle of an MDR grant.
    do_reset();
    bus_if.req  = 4'b0010;
    bus_if.lock = 4'b0010;
    tick(); check_out("pre_async", GATE_MDR, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", GATE_NONE, 1'b0, 1'b0);
    bus_if.req  = 4'b1111;
    bus_if.lock = 4'b0000;
    #2;
    rst_n = 1'b1;
    tick(); check_out("post_rst", GATE_PC, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
